apb_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one APB master's command interface (transfer, write_read, addr_in, wdata_in, strb_in) between NUM_REQ requesters.
- Accepts one request at a time and holds the command stable until the master reports transfer_done.
- Routes rdata_out and error back to the winning requester as a one-cycle response.
- Adds a watchdog timeout so a hung slave cannot lock out the other requesters.

---
 rtl/apb_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master command port between requesters
module apb_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]   req_strb,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_error,
    output logic                        rsp_timeout,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        transfer,
    output logic                        write_read,
    output logic [ADDR_W-1:0]           addr_in,
    output logic [DATA_W-1:0]           wdata_in,
    output logic [STRB_W-1:0]           strb_in,
    input  logic                        transfer_done,
    input  logic                        error,
    input  logic [DATA_W-1:0]           rdata_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Last counter value of an ISSUE phase before the watchdog fires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state logic: accept in IDLE, wait for completion or watchdog in ISSUE, pulse response in RESP.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    wr_d    = req_write[win_id];
                    addr_d  = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(win_id)*DATA_W +: DATA_W];
                    strb_d  = req_strb[int'(win_id)*STRB_W +: STRB_W];
                    grant_d = win_id;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (transfer_done) begin
                    rdata_d = wr_q ? '0 : rdata_out;
                    err_d   = error;
                    to_d    = 1'b0;
                    last_d  = grant_q;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    last_d  = grant_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            last_q  <= ID_W'(NUM_REQ - 1);
            grant_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        req_ready   = (!PRESET && state_q == S_IDLE && win_found) ? (ONE_HOT0 << win_id) : '0;
        rsp_valid   = (state_q == S_RESP) ? (ONE_HOT0 << grant_q) : '0;
        transfer    = (state_q == S_ISSUE);
        busy        = (state_q != S_IDLE);
        grant_id    = grant_q;
        write_read  = wr_q;
        addr_in     = addr_q;
        wdata_in    = wdata_q;
        strb_in     = strb_q;
        rsp_rdata   = rdata_q;
        rsp_error   = err_q;
        rsp_timeout = to_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

    logic         PCLK = 1'b0;
    logic         PRESET = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [3:0]   req_write = '0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_strb = '0;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;
    logic         rsp_timeout;
    logic         busy;
    logic [1:0]   grant_id;
    logic         transfer;
    logic         write_read;
    logic [7:0]   addr_in;
    logic [31:0]  wdata_in;
    logic [3:0]   strb_in;
    logic         transfer_done = 1'b0;
    logic         error = 1'b0;
    logic [31:0]  rdata_out = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    apb_req_arbiter #(
        .NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYC(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .busy(busy), .grant_id(grant_id),
        .transfer(transfer), .write_read(write_read), .addr_in(addr_in),
        .wdata_in(wdata_in), .strb_in(strb_in), .transfer_done(transfer_done),
        .error(error), .rdata_out(rdata_out)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Response scoreboard: every rsp_valid pulse must match the oldest expected response.
    always @(negedge PCLK) begin
        if (rsp_valid !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b, required no response", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_valid, rsp_rdata, rsp_error, rsp_timeout} !==
                    {4'b0001 << mon_e.id, mon_e.rdata, mon_e.err, mon_e.to}) begin
                    errors++;
                    $display("FAIL rsp_match: got valid=%b rdata=%h err=%b to=%b, required valid=%b rdata=%h err=%b to=%b",
                             rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
                             4'b0001 << mon_e.id, mon_e.rdata, mon_e.err, mon_e.to);
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [31:0] rd, input logic er, input logic to);
        exp_t e;
        e.id    = 2'(id);
        e.rdata = rd;
        e.err   = er;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i]        = w;
        req_addr[i*8 +: 8]  = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]  = s;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if ({req_ready, rsp_valid, busy, transfer, grant_id} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b transfer=%b grant=%0d, required all 0",
                     req_ready, rsp_valid, busy, transfer, grant_id);
        end
        checks++;
        if ({write_read, addr_in, wdata_in, strb_in, rsp_rdata, rsp_error, rsp_timeout} !== 79'h0) begin
            errors++;
            $display("FAIL reset_data: wr=%b addr=%h wdata=%h strb=%h rdata=%h err=%b to=%b, required all 0",
                     write_read, addr_in, wdata_in, strb_in, rsp_rdata, rsp_error, rsp_timeout);
        end
        transfer_done = 1'b1;
        rdata_out = 32'hCAFE0000;
        tick();
        transfer_done = 1'b0;
        rdata_out = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL idle_done_ignored: busy=%b rsp_valid=%b, required 0 and 0000", busy, rsp_valid);
        end
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 8'h10, 32'h0, 4'h0);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL read_ready: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        push_exp(2, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++;
        if ({transfer, write_read, addr_in, busy, grant_id} !== {1'b1, 1'b0, 8'h10, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL read_issue: transfer=%b wr=%b addr=%h busy=%b grant=%0d, required 1 0 10 1 2",
                     transfer, write_read, addr_in, busy, grant_id);
        end
        tick();
        tick();
        transfer_done = 1'b1;
        rdata_out = 32'hDEADBEEF;
        tick();
        transfer_done = 1'b0;
        rdata_out = '0;
        checks++;
        if (transfer !== 1'b0 || rsp_valid !== 4'b0100) begin
            errors++;
            $display("FAIL read_resp: transfer=%b rsp_valid=%b, required 0 and 0100", transfer, rsp_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_back_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_write_error();
        set_req(1, 1'b1, 8'h20, 32'h12345678, 4'b0011);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL write_ready: got %b, required 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        set_req(1, 1'b0, 8'hFF, 32'hFFFFFFFF, 4'hF);
        push_exp(1, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({transfer, write_read, addr_in, wdata_in, strb_in} !==
                {1'b1, 1'b1, 8'h20, 32'h12345678, 4'b0011}) begin
                errors++;
                $display("FAIL write_hold[%0d]: transfer=%b wr=%b addr=%h wdata=%h strb=%b, required 1 1 20 12345678 0011",
                         c, transfer, write_read, addr_in, wdata_in, strb_in);
            end
            if (c < 2) tick();
        end
        transfer_done = 1'b1;
        error = 1'b1;
        rdata_out = 32'hFFFFFFFF;
        tick();
        transfer_done = 1'b0;
        error = 1'b0;
        rdata_out = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 32'h0, 4'h0);
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            exp_rdy = 4'b0001 << (n % 4);
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b, required %b", n, req_ready, exp_rdy);
            end
            tick();
            checks++;
            if ({transfer, grant_id, addr_in} !== {1'b1, 2'(n % 4), 8'h40 + 8'(n % 4)}) begin
                errors++;
                $display("FAIL rr_issue[%0d]: transfer=%b grant=%0d addr=%h, required 1 %0d %h",
                         n, transfer, grant_id, addr_in, n % 4, 8'h40 + 8'(n % 4));
            end
            transfer_done = 1'b1;
            rdata_out = 32'hA0000000 + 32'(n);
            push_exp(n % 4, 32'hA0000000 + 32'(n), 1'b0, 1'b0);
            tick();
            transfer_done = 1'b0;
            rdata_out = '0;
            checks++;
            if (transfer !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap[%0d]: transfer=%b ready=%b in RESP, required 0 and 0000", n, transfer, req_ready);
            end
            tick();
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        int cycles;
        set_req(0, 1'b0, 8'h30, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h31, 32'h0, 4'h0);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL to_ready: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        push_exp(0, 32'h0, 1'b1, 1'b1);
        cycles = 0;
        while (transfer === 1'b1 && cycles < 20) begin
            cycles++;
            tick();
        end
        checks++;
        if (cycles != 4) begin
            errors++;
            $display("FAIL to_length: transfer high %0d cycles, required 4", cycles);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL to_next_ready: got %b, required 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        push_exp(1, 32'h55AA55AA, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (transfer !== 1'b1) begin
            errors++;
            $display("FAIL to_edge_issue: transfer=%b on 4th ISSUE cycle, required 1", transfer);
        end
        transfer_done = 1'b1;
        rdata_out = 32'h55AA55AA;
        tick();
        transfer_done = 1'b0;
        rdata_out = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b1, 8'h50, 32'h0BADF00D, 4'hF);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        PRESET = 1'b1;
        tick();
        checks++;
        if ({transfer, rsp_valid, busy, grant_id} !== 8'h00) begin
            errors++;
            $display("FAIL midreset: transfer=%b rsp_valid=%b busy=%b grant=%0d, required all 0",
                     transfer, rsp_valid, busy, grant_id);
        end
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h60 + 8'(i), 32'h0, 4'h0);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_prio: ready=%b, required 0001", req_ready);
        end
        req_valid = 4'b0000;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_error();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
